// File: rtl/sram_ws_wrapper_pkg.sv
// rtl/sram_ws_wrapper_pkg.sv - shared geometry, state encodings and helpers for the SRAM line wrapper
package sram_ws_wrapper_pkg;

   // Array geometry: three 16-bit chips side by side form one 48-bit word
   localparam int WORDS_PER_LINE = 16;
   localparam int WORD_W         = 48;
   localparam int ADDR_W         = 20;
   localparam int CHIPS          = 3;

   // Derived widths
   localparam int MASK_W      = WORD_W / 8;
   localparam int LINE_W      = WORDS_PER_LINE * WORD_W;
   localparam int LINE_MASK_W = WORDS_PER_LINE * MASK_W;
   localparam int IDX_W       = $clog2(WORDS_PER_LINE);
   localparam int LINE_IDX_W  = ADDR_W - IDX_W;
   localparam int LINE_LSB    = 6;

   // Line sequencer states
   typedef enum logic [1:0] {
      WS_IDLE,
      WS_ISSUE,
      WS_WAIT,
      WS_DONE
   } ws_state_t;

   // Single-word chip controller states
   typedef enum logic [1:0] {
      CC_IDLE,
      CC_ACCESS,
      CC_CAPTURE
   } cc_state_t;

   // A chip takes part in a write when either of its two byte lanes is enabled
   function automatic logic [CHIPS-1:0] chip_enables(input logic [MASK_W-1:0] mask);
      logic [CHIPS-1:0] en;
      for (int k = 0; k < CHIPS; k++) begin
         en[k] = mask[2*k] | mask[2*k+1];
      end
      return en;
   endfunction

endpackage

// File: rtl/sram_chip_ctrl.sv
// rtl/sram_chip_ctrl.sv - single-word async SRAM access controller owning all chip pins
module sram_chip_ctrl
   import sram_ws_wrapper_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              strobe,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [MASK_W-1:0] mask,
   output logic [WORD_W-1:0] rdata,
   output logic              busy,
   output logic [CHIPS-1:0]  sram_ce_n,
   output logic [CHIPS-1:0]  sram_oe_n,
   output logic [CHIPS-1:0]  sram_we_n,
   output logic [CHIPS-1:0]  sram_ub_n,
   output logic [CHIPS-1:0]  sram_lb_n,
   output logic [ADDR_W-1:0] sram_addr,
   inout  wire  [WORD_W-1:0] sram_data
);

   cc_state_t         state;
   cc_state_t         state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] data_q;
   logic [MASK_W-1:0] mask_q;
   logic              wr_q;
   logic              drive_en;

   // A write with an empty mask degenerates into a plain read cycle
   // so the access timing stays identical for every word.
   assign sram_addr = addr_q;
   assign sram_data = drive_en ? data_q : {WORD_W{1'bz}};

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= CC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the request on strobe and register read data at the end of capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
         data_q <= '0;
         mask_q <= '0;
         wr_q   <= 1'b0;
         rdata  <= '0;
      end else begin
         if (state == CC_IDLE && strobe) begin
            addr_q <= addr;
            data_q <= wdata;
            mask_q <= mask;
            wr_q   <= we && (mask != '0);
         end
         if (state == CC_CAPTURE && !wr_q) begin
            rdata <= sram_data;
         end
      end
   end

   // Next-state: fixed two-cycle access once strobed
   always_comb begin
      state_nxt = state;
      case (state)
         CC_IDLE:    if (strobe) state_nxt = CC_ACCESS;
         CC_ACCESS:  state_nxt = CC_CAPTURE;
         CC_CAPTURE: state_nxt = CC_IDLE;
         default:    state_nxt = CC_IDLE;
      endcase
   end

   // Pin decode: we_n low only in ACCESS so address/data straddle its release
   always_comb begin
      busy      = 1'b0;
      drive_en  = 1'b0;
      sram_ce_n = '1;
      sram_oe_n = '1;
      sram_we_n = '1;
      sram_ub_n = '1;
      sram_lb_n = '1;
      if (state == CC_ACCESS || state == CC_CAPTURE) begin
         busy      = 1'b1;
         sram_ce_n = '0;
         for (int k = 0; k < CHIPS; k++) begin
            sram_lb_n[k] = ~mask_q[2*k];
            sram_ub_n[k] = ~mask_q[2*k+1];
         end
         if (wr_q) begin
            drive_en = 1'b1;
            if (state == CC_ACCESS) begin
               sram_we_n = ~chip_enables(mask_q);
            end
         end else begin
            sram_oe_n = '0;
         end
      end
   end

endmodule

// File: rtl/sram_ws_wrapper.sv
// rtl/sram_ws_wrapper.sv - cache-line front end serialising 16 word accesses to the external SRAM
module sram_ws_wrapper
   import sram_ws_wrapper_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            ws_addr,
   input  logic [LINE_W-1:0]      ws_din,
   input  logic [LINE_MASK_W-1:0] ws_dm,
   input  logic                   ws_stb,
   input  logic                   ws_we,
   output logic                   ws_ack,
   output logic [LINE_W-1:0]      ws_dout,
   output logic [CHIPS-1:0]       sram_ce_n,
   output logic [CHIPS-1:0]       sram_oe_n,
   output logic [CHIPS-1:0]       sram_we_n,
   output logic [CHIPS-1:0]       sram_ub_n,
   output logic [CHIPS-1:0]       sram_lb_n,
   output logic [ADDR_W-1:0]      sram_addr,
   inout  wire  [WORD_W-1:0]      sram_data
);

   ws_state_t              state;
   ws_state_t              state_nxt;
   logic [IDX_W-1:0]       idx;
   logic [LINE_IDX_W-1:0]  line_q;
   logic [LINE_W-1:0]      din_q;
   logic [LINE_MASK_W-1:0] dm_q;
   logic                   we_q;
   logic                   last_word;

   logic                   ctrl_strobe;
   logic                   ctrl_busy;
   logic [ADDR_W-1:0]      ctrl_addr;
   logic [WORD_W-1:0]      ctrl_wdata;
   logic [MASK_W-1:0]      ctrl_mask;
   logic [WORD_W-1:0]      ctrl_rdata;

   // Only the line index is meaningful; offset and upper bits are don't-care
   logic unused_addr_bits;
   assign unused_addr_bits = ^{ws_addr[31:LINE_LSB+LINE_IDX_W], ws_addr[LINE_LSB-1:0]};

   assign last_word  = (idx == IDX_W'(WORDS_PER_LINE - 1));
   assign ctrl_addr  = {line_q, idx};
   assign ctrl_wdata = din_q[idx*WORD_W +: WORD_W];
   // Reads enable every byte lane; writes use the caller's per-word mask
   assign ctrl_mask  = we_q ? dm_q[idx*MASK_W +: MASK_W] : {MASK_W{1'b1}};

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= WS_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Request latch at acceptance, word counter and read-line assembly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx     <= '0;
         line_q  <= '0;
         din_q   <= '0;
         dm_q    <= '0;
         we_q    <= 1'b0;
         ws_dout <= '0;
      end else begin
         if (state == WS_IDLE && ws_stb) begin
            idx    <= '0;
            line_q <= ws_addr[LINE_LSB +: LINE_IDX_W];
            din_q  <= ws_din;
            dm_q   <= ws_dm;
            we_q   <= ws_we;
         end
         if (state == WS_WAIT && !ctrl_busy) begin
            if (!we_q) begin
               ws_dout[idx*WORD_W +: WORD_W] <= ctrl_rdata;
            end
            if (!last_word) begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   // Next-state: issue/wait per word, then a single ack cycle
   always_comb begin
      state_nxt = state;
      case (state)
         WS_IDLE:  if (ws_stb) state_nxt = WS_ISSUE;
         WS_ISSUE: state_nxt = WS_WAIT;
         WS_WAIT:  if (!ctrl_busy) state_nxt = last_word ? WS_DONE : WS_ISSUE;
         WS_DONE:  state_nxt = WS_IDLE;
         default:  state_nxt = WS_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      ctrl_strobe = (state == WS_ISSUE);
      ws_ack      = (state == WS_DONE);
   end

   sram_chip_ctrl u_chip_ctrl (
      .clk       (clk),
      .rst       (rst),
      .strobe    (ctrl_strobe),
      .we        (we_q),
      .addr      (ctrl_addr),
      .wdata     (ctrl_wdata),
      .mask      (ctrl_mask),
      .rdata     (ctrl_rdata),
      .busy      (ctrl_busy),
      .sram_ce_n (sram_ce_n),
      .sram_oe_n (sram_oe_n),
      .sram_we_n (sram_we_n),
      .sram_ub_n (sram_ub_n),
      .sram_lb_n (sram_lb_n),
      .sram_addr (sram_addr),
      .sram_data (sram_data)
   );

endmodule

// File: tb/tb_sram_ws_wrapper.sv
// tb/tb_sram_ws_wrapper.sv - directed self-checking bench for the SRAM line wrapper
module tb_sram_ws_wrapper;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  ws_addr;
   logic [767:0] ws_din;
   logic [95:0]  ws_dm;
   logic         ws_stb;
   logic         ws_we;
   logic         ws_ack;
   logic [767:0] ws_dout;
   logic [2:0]   sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
   logic [19:0]  sram_addr;
   wire  [47:0]  sram_data;

   logic [47:0]  mem [0:(1<<20)-1];
   logic         probe_en;
   logic [47:0]  probe_val;
   logic         mdl_en;

   int n_pass  = 0;
   int n_total = 0;

   logic [19:0] rd_addr_q[$];
   logic [19:0] wr_addr_q[$];
   logic [8:0]  wr_ctl_q[$];

   always #5 clk = ~clk;

   sram_ws_wrapper dut (
      .clk       (clk),
      .rst       (rst),
      .ws_addr   (ws_addr),
      .ws_din    (ws_din),
      .ws_dm     (ws_dm),
      .ws_stb    (ws_stb),
      .ws_we     (ws_we),
      .ws_ack    (ws_ack),
      .ws_dout   (ws_dout),
      .sram_ce_n (sram_ce_n),
      .sram_oe_n (sram_oe_n),
      .sram_we_n (sram_we_n),
      .sram_ub_n (sram_ub_n),
      .sram_lb_n (sram_lb_n),
      .sram_addr (sram_addr),
      .sram_data (sram_data)
   );

   // SRAM read drive, or a probe pattern used to show the DUT leaves the bus floating
   assign mdl_en    = (sram_ce_n != 3'b111) && (sram_oe_n != 3'b111) && (sram_we_n == 3'b111);
   assign sram_data = probe_en ? probe_val : (mdl_en ? mem[sram_addr] : 48'bz);

   function automatic logic [47:0] pre_low(input int a);
      return 48'hC0DE_0000_0000 + 48'(a);
   endfunction

   function automatic logic [47:0] pre_top(input int i);
      return 48'(i) * 48'h0101_0101_0101;
   endfunction

   function automatic logic [47:0] pre_mid(input int i);
      return 48'hA5A4_A3A2_A1A0 + 48'(i);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic start_req(input logic [31:0] a, input logic w, input logic [767:0] d, input logic [95:0] m);
      ws_addr = a;
      ws_we   = w;
      ws_din  = d;
      ws_dm   = m;
      ws_stb  = 1'b1;
   endtask

   task automatic wait_ack(input int limit, output int n);
      n = -1;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (c == 1) ws_stb = 1'b0;
         if (ws_ack) begin
            n = c;
            break;
         end
      end
   endtask

   // Behavioural SRAM: byte-lane writes while we_n is low, logging of write and read accesses
   initial begin : sram_model
      logic        rd_prev;
      logic [19:0] a;
      rd_prev = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = pre_low(i);
      for (int i = 0; i < 16; i++) begin
         mem[20'hFFFF0 + 20'(i)] = pre_top(i);
         mem[32 + i]             = pre_mid(i);
      end
      forever begin
         @(negedge clk);
         a = sram_addr;
         if (sram_we_n != 3'b111) begin
            wr_addr_q.push_back(a);
            wr_ctl_q.push_back({sram_we_n, sram_ub_n, sram_lb_n});
            for (int k = 0; k < 3; k++) begin
               if (!sram_we_n[k] && !sram_ce_n[k]) begin
                  if (!sram_lb_n[k]) mem[a][16*k +: 8]   = sram_data[16*k +: 8];
                  if (!sram_ub_n[k]) mem[a][16*k+8 +: 8] = sram_data[16*k+8 +: 8];
               end
            end
         end
         if ((sram_oe_n != 3'b111) && !rd_prev) rd_addr_q.push_back(a);
         rd_prev = (sram_oe_n != 3'b111);
      end
   end

   initial begin : stim
      int           n, n2, rb, wb, acks;
      logic [63:0]  acc;
      logic [47:0]  exp_w;
      logic [767:0] din_v;

      rst = 1'b0; ws_addr = '0; ws_din = '0; ws_dm = '0; ws_stb = 1'b0; ws_we = 1'b0;
      probe_en = 1'b0; probe_val = 48'h5A5A_C3C3_0F0F;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ce_n", 64'(sram_ce_n), 64'h7);
      chk("rst_oe_n", 64'(sram_oe_n), 64'h7);
      chk("rst_we_n", 64'(sram_we_n), 64'h7);
      chk("rst_ub_n", 64'(sram_ub_n), 64'h7);
      chk("rst_lb_n", 64'(sram_lb_n), 64'h7);
      chk("rst_addr", 64'(sram_addr), 64'h0);
      chk("rst_ack", 64'(ws_ack), 64'h0);
      chk("rst_dout", 64'(|ws_dout), 64'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ack", 64'(ws_ack), 64'h0);
      chk("idle_ce_n", 64'(sram_ce_n), 64'h7);
      probe_en = 1'b1; #1;
      chk("idle_bus_z", 64'(sram_data), 64'(probe_val));
      probe_en = 1'b0;
      @(negedge clk);

      // Full write of line 0 then line 0x40 with zero data
      for (int ln = 0; ln < 2; ln++) begin
         wb = wr_addr_q.size();
         start_req(32'(ln * 32'h40), 1'b1, '0, '1);
         wait_ack(150, n);
         chk($sformatf("wr%0d_ack_cyc", ln), 64'(n), 64'd65);
         @(negedge clk);
         chk($sformatf("wr%0d_ack_low", ln), 64'(ws_ack), 64'h0);
         chk($sformatf("wr%0d_cnt", ln), 64'(wr_addr_q.size() - wb), 64'd16);
         for (int i = 0; i < 16; i++) begin
            chk($sformatf("wr%0d_w%0d", ln, i), {35'h0, wr_addr_q[wb+i], wr_ctl_q[wb+i]},
                {35'h0, 20'(16 * ln + i), 9'b000_000_000});
         end
      end
      acc = '0;
      for (int i = 0; i < 32; i++) acc = acc | 64'(mem[i]);
      chk("wr_mem_zero", acc, 64'h0);

      // Read of the top line from the preloaded model
      rb = rd_addr_q.size();
      start_req(32'h003F_FFC0, 1'b0, {12{64'hDEAD_BEEF_DEAD_BEEF}}, '1);
      wait_ack(150, n);
      chk("rd_ack_cyc", 64'(n), 64'd65);
      chk("rd_cnt", 64'(rd_addr_q.size() - rb), 64'd16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("rd_addr%0d", i), 64'(rd_addr_q[rb+i]), 64'(20'hFFFF0 + 20'(i)));
         chk($sformatf("rd_word%0d", i), 64'(ws_dout[48*i +: 48]), 64'(pre_top(i)));
      end
      @(negedge clk);

      // Partial write: only chip 0 of word 3 on line 0x80
      for (int i = 0; i < 16; i++) din_v[48*i +: 48] = (i == 3) ? 48'h1111_2222_3333 : 48'hFFFF_FFFF_FFFF;
      wb = wr_addr_q.size();
      rb = rd_addr_q.size();
      start_req(32'h0000_0080, 1'b1, din_v, 96'h3 << 18);
      wait_ack(150, n);
      chk("pw_ack_cyc", 64'(n), 64'd65);
      chk("pw_wr_cnt", 64'(wr_addr_q.size() - wb), 64'd1);
      chk("pw_wr_addr", 64'(wr_addr_q[wb]), 64'd35);
      chk("pw_wr_ctl", 64'(wr_ctl_q[wb]), 64'(9'b110_110_110));
      chk("pw_rd_cnt", 64'(rd_addr_q.size() - rb), 64'd15);
      chk("pw_dout_keep1", 64'(ws_dout[48*1 +: 48]), 64'(pre_top(1)));
      chk("pw_dout_keep15", 64'(ws_dout[48*15 +: 48]), 64'(pre_top(15)));
      @(negedge clk);
      probe_en = 1'b1; #1;
      chk("pw_bus_z", 64'(sram_data), 64'(probe_val));
      probe_en = 1'b0;
      @(negedge clk);

      // Strobe held across ack: back-to-back requests, address latched at acceptance only
      rb = rd_addr_q.size();
      n = -1; n2 = -1;
      start_req(32'h003F_FFC0, 1'b0, '0, '0);
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (c == 20) ws_addr = 32'h0000_0080;
         if (c == 67) begin
            ws_stb  = 1'b0;
            ws_addr = 32'h0;
         end
         if (ws_ack) begin
            if (n < 0) begin
               n = c;
               chk("b2b_first_word15", 64'(ws_dout[48*15 +: 48]), 64'(pre_top(15)));
            end else begin
               n2 = c;
               break;
            end
         end
      end
      chk("b2b_ack1_cyc", 64'(n), 64'd65);
      chk("b2b_ack2_cyc", 64'(n2), 64'd131);
      chk("b2b_rd_cnt", 64'(rd_addr_q.size() - rb), 64'd32);
      chk("b2b_first_last_addr", 64'(rd_addr_q[rb+15]), 64'hFFFFF);
      chk("b2b_second_first_addr", 64'(rd_addr_q[rb+16]), 64'd32);
      chk("b2b_second_last_addr", 64'(rd_addr_q[rb+31]), 64'd47);
      for (int i = 0; i < 16; i++) begin
         exp_w = pre_mid(i);
         if (i == 3) exp_w[15:0] = 16'h3333;
         chk($sformatf("b2b_rb_word%0d", i), 64'(ws_dout[48*i +: 48]), 64'(exp_w));
      end
      @(negedge clk);

      // Reset during word 7 of a read aborts it without ack
      start_req(32'h003F_FFC0, 1'b0, '0, '0);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) ws_stb = 1'b0;
      end
      chk("mid_oe_active", 64'(sram_oe_n), 64'h0);
      chk("mid_addr_w7", 64'(sram_addr), 64'hFFFF7);
      rst = 1'b0; #1;
      chk("mid_rst_ce_n", 64'(sram_ce_n), 64'h7);
      chk("mid_rst_oe_n", 64'(sram_oe_n), 64'h7);
      chk("mid_rst_we_n", 64'(sram_we_n), 64'h7);
      chk("mid_rst_ublb", 64'({sram_ub_n, sram_lb_n}), 64'h3F);
      chk("mid_rst_addr", 64'(sram_addr), 64'h0);
      chk("mid_rst_ack", 64'(ws_ack), 64'h0);
      chk("mid_rst_dout", 64'(|ws_dout), 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      acks = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (ws_ack) acks++;
      end
      chk("mid_rst_no_ack", 64'(acks), 64'h0);

      // Next request after the abort completes normally
      start_req(32'h003F_FFC0, 1'b0, '0, '0);
      wait_ack(150, n);
      chk("post_rst_ack_cyc", 64'(n), 64'd65);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("post_rst_word%0d", i), 64'(ws_dout[48*i +: 48]), 64'(pre_top(i)));
      end
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
